// File: rtl/lab7soc_pio_in_edge.sv
// rtl/lab7soc_pio_in_edge.sv - synchronised, debounced, edge-capturing input PIO with level IRQ
// Optional debounce counters are enabled by defining PIO_DEBOUNCE_EN.
module lab7soc_pio_in_edge #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] qual;
    logic [WIDTH-1:0] clear;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic             wr;

    assign wr    = chipselect & ~write_n;
    assign clear = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

`ifdef PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt [WIDTH];

    // A channel is accepted once s2 has disagreed with d for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s2[i] != d[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == d[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign accept = s2 ^ d;
`endif

    // accept always flips d, so the post-accept level equals s2.
    always_comb begin
        qual = '0;
        case (EDGE_TYPE)
            0:       qual = accept & s2;
            1:       qual = accept & ~s2;
            default: qual = accept;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= '0;
            s2          <= '0;
            d           <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
            d  <= d ^ accept;
            if (wr && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // A new edge wins over a simultaneous write-1-to-clear.
            edgecapture <= (edgecapture & ~clear) | qual;
            case (address)
                2'd0:    readdata <= 32'(d);
                2'd2:    readdata <= 32'(irqmask);
                2'd3:    readdata <= 32'(edgecapture);
                default: readdata <= '0;
            endcase
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_lab7soc_pio_in_edge.sv
// tb/tb_lab7soc_pio_in_edge.sv - scoreboard bench for lab7soc_pio_in_edge across all three EDGE_TYPE modes
module tb_lab7soc_pio_in_edge;

    localparam int W  = 2;
    localparam int DB = 16;
`ifdef PIO_DEBOUNCE_EN
    localparam int EFF_D = DB;
`else
    localparam int EFF_D = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'd0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   rd [3];
    logic          irq_o [3];

    always #5 clk = ~clk;

    lab7soc_pio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(0)) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq_o[0]));
    lab7soc_pio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(1)) u_dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq_o[1]));
    lab7soc_pio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(2)) u_dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq_o[2]));

    typedef struct packed {
        logic [2:0][31:0] rd;
        logic [2:0]       irq;
    } exp_t;

    exp_t              sb [$];
    int                checks = 0;
    int                failures = 0;
    logic [W-1:0]      hist [$];
    logic [W-1:0]      m_d;
    logic [2:0][W-1:0] m_mask;
    logic [2:0][W-1:0] m_ec;
    logic [W-1:0]      pins = '0;
    int                hold [W];

    // Pin value applied before post-reset edge j+1; anything before the first edge reads as 0.
    function automatic logic [W-1:0] pin_at(input int idx);
        if (idx >= 0 && idx < hist.size()) return hist[idx];
        return '0;
    endfunction

    // Reference: a bit is accepted when the synchronised pin (2 edges old) has shown the
    // opposite of the stable level for the last EFF_D edges.
    task automatic model_edge(input logic rst);
        exp_t         e;
        logic [W-1:0] acc;
        logic [W-1:0] q;
        logic [W-1:0] clr;
        logic [W-1:0] s;
        logic         wr;
        logic         stable;
        e = '0;
        if (rst) begin
            hist.delete();
            m_d    = '0;
            m_mask = '0;
            m_ec   = '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                case (address)
                    2'd0:    e.rd[k] = 32'(m_d);
                    2'd2:    e.rd[k] = 32'(m_mask[k]);
                    2'd3:    e.rd[k] = 32'(m_ec[k]);
                    default: e.rd[k] = 32'd0;
                endcase
            end
            hist.push_back(in_port);
            acc = '0;
            for (int i = 0; i < W; i++) begin
                stable = 1'b1;
                for (int k = 0; k < EFF_D; k++) begin
                    s = pin_at(hist.size() - 3 - k);
                    if (s[i] == m_d[i]) stable = 1'b0;
                end
                acc[i] = stable;
            end
            wr  = chipselect && !write_n;
            clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
            for (int k = 0; k < 3; k++) begin
                q = (k == 0) ? (acc & ~m_d) : (k == 1) ? (acc & m_d) : acc;
                m_ec[k] = (m_ec[k] & ~clr) | q;
                if (wr && address == 2'd2) m_mask[k] = writedata[W-1:0];
                e.irq[k] = |(m_ec[k] & m_mask[k]);
            end
            m_d = m_d ^ acc;
        end
        sb.push_back(e);
    endtask

    task automatic cyc(input logic rst, input logic [1:0] a, input logic wr_en,
                       input logic [31:0] wd, input logic [W-1:0] p);
        @(negedge clk);
        reset     = rst;
        address   = a;
        writedata = wd;
        in_port   = p;
        if (wr_en) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
            chipselect = 1'b1;
            write_n    = 1'b1;
        end else begin
            chipselect = 1'b0;
            write_n    = 1'($urandom_range(0, 1));
        end
        model_edge(rst);
    endtask

    task automatic idle(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) cyc(1'b0, a, 1'b0, $urandom, pins);
    endtask

    task automatic idle_alt(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, (i % 2 == 0) ? 2'd0 : 2'd3, 1'b0, $urandom, pins);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (rd[k] !== e.rd[k]) begin
                        failures++;
                        $display("FAIL readdata edge_type=%0d t=%0t got=%h exp=%h", k, $time, rd[k], e.rd[k]);
                    end
                    checks++;
                    if (irq_o[k] !== e.irq[k]) begin
                        failures++;
                        $display("FAIL irq edge_type=%0d t=%0t got=%b exp=%b", k, $time, irq_o[k], e.irq[k]);
                    end
                end
            end
        end
    end

    initial begin
        int r;
        // Reset, then read every address.
        cyc(1'b1, 2'd0, 1'b0, 32'd0, pins);
        cyc(1'b1, 2'd0, 1'b0, 32'd0, pins);
        for (int a = 0; a < 4; a++) cyc(1'b0, 2'(a), 1'b0, 32'hFFFF_FFFF, pins);
        cyc(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, pins);
        cyc(1'b0, 2'd0, 1'b1, 32'hFFFF_FFFF, pins);
        idle(2, 2'd0);

        // Mask bit 0, step pin 0 high.
        cyc(1'b0, 2'd2, 1'b1, 32'h1, pins);
        pins[0] = 1'b1;
        idle_alt(EFF_D + 6);

        // Short pulse on pin 1.
        pins[1] = 1'b1;
        idle(10, 2'd0);
        pins[1] = 1'b0;
        idle_alt(EFF_D + 8);

        // Clear on the same edge as a new rising accept on bit 0.
        pins[0] = 1'b0;
        idle_alt(EFF_D + 6);
        pins[0] = 1'b1;
        cyc(1'b0, 2'd3, 1'b0, 32'd0, pins);
        idle(EFF_D, 2'd3);
        cyc(1'b0, 2'd3, 1'b1, 32'h1, pins);
        idle(2, 2'd3);
        cyc(1'b0, 2'd3, 1'b1, 32'h1, pins);
        idle(2, 2'd3);

        // Both edge directions with a clear between them.
        cyc(1'b0, 2'd2, 1'b1, 32'h3, pins);
        pins[0] = 1'b0;
        idle_alt(EFF_D + 4);
        cyc(1'b0, 2'd3, 1'b1, 32'h3, pins);
        pins[0] = 1'b1;
        idle_alt(EFF_D + 4);

        // One-cycle glitch on pin 1.
        pins[1] = 1'b1;
        cyc(1'b0, 2'd3, 1'b0, 32'd0, pins);
        pins[1] = 1'b0;
        idle(EFF_D + 4, 2'd3);

        // Mask set after capture, then mask cleared.
        cyc(1'b0, 2'd2, 1'b1, 32'h0, pins);
        idle(2, 2'd3);
        cyc(1'b0, 2'd2, 1'b1, 32'h3, pins);
        idle(2, 2'd2);

        // Reset mid-debounce with the pin held high.
        pins = 2'b11;
        cyc(1'b0, 2'd0, 1'b0, 32'd0, pins);
        pins = 2'b10;
        idle(EFF_D / 2 + 3, 2'd0);
        cyc(1'b1, 2'd0, 1'b0, 32'd0, pins);
        cyc(1'b0, 2'd2, 1'b1, 32'h3, pins);
        idle_alt(EFF_D + 6);

        // Randomised traffic.
        for (int i = 0; i < W; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++) begin
                if (hold[i] == 0) begin
                    pins[i] = ~pins[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(1, 3 * EFF_D + 4));
                end else begin
                    hold[i]--;
                end
            end
            r = int'($urandom_range(0, 9));
            if (r == 0)      cyc(1'b0, 2'd2, 1'b1, $urandom, pins);
            else if (r <= 2) cyc(1'b0, 2'd3, 1'b1, $urandom, pins);
            else             cyc(1'b0, 2'($urandom_range(0, 3)), 1'b0, $urandom, pins);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lab7soc_pio_in_edge.md
Name: lab7soc_pio_in_edge

Overview:
Parametrised Avalon-MM input PIO for push-buttons and switches. It supersedes the plain button reader with per-channel synchronisation, debounce, edge capture, an interrupt mask and a level IRQ output. It sits on the lab7soc system bus between the board input pins and the Nios II, which reads levels and services edge interrupts.

Parameters:
WIDTH, 2, number of input channels (1..32).
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a level change is accepted (>=1). The internal counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
EDGE_TYPE, 0, capture mode applied to all channels: 0 = rising, 1 = falling, 2 = any edge.

Ports:
clk  in  1  system clock; the block's only clock.
reset  in  1  synchronous, active-high reset.
address  in  2  register word address.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe.
writedata  in  32  write data; bits [WIDTH-1:0] are used.
in_port  in  WIDTH  raw asynchronous pin inputs.
readdata  out  32  registered read data.
irq  out  1  level interrupt, active high.

Behaviour:
- Reset: the following all go to 0 on the first clk edge with reset=1:
  - readdata and irq
  - sync flops (2 per channel), debounce counters, stable level d
  - irqmask and edgecapture
- Reset has priority over every other event. Reset asserted mid-debounce discards the partial count.
- Synchroniser: s1 <= in_port; s2 <= s1. s2 is first valid 2 edges after the pin changes.
- Debounce, per channel, each edge:
  - If s2 == d: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: d <= s2, cnt <= 0, and the channel raises an "accept" event.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES resets cnt and d never changes.
- Latency: a clean pin step is reflected in d, and in edgecapture where applicable, DEBOUNCE_CYCLES+2 edges after the pin change.
- Edge detect: an accept event with new d=1 is a rising edge; with new d=0 it is a falling edge. The event is qualified by EDGE_TYPE. A qualifying edge sets edgecapture[i] on the same edge d updates.
- Register map (reads are 1-cycle latency; readdata <= mux(address) every clock, independent of chipselect; unused upper bits read 0):
  - 0 DATA: read d, zero-extended; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 IRQMASK: read/write; mask <= writedata[WIDTH-1:0].
  - 3 EDGECAPTURE: read; write-1-to-clear per bit.
- A write occurs when chipselect=1 and write_n=0, and takes effect on that edge.
- Simultaneous clear and new qualifying edge on the same bit in the same cycle: the set wins, and the bit remains 1.
- irq = |(edgecapture & irqmask), computed from registers, so there are no combinational paths from the bus.
  - Clearing a bit or its mask deasserts irq on the same edge the register updates.
  - Setting the mask for an already-captured bit asserts irq on the mask-write edge.
- Post-reset: a pin held high through reset is accepted as a 0->1 change after the debounce period. It therefore captures a rising edge (EDGE_TYPE 0 or 2). Firmware must clear EDGECAPTURE during init.
- Counters saturate by construction and never wrap: cnt is bounded by DEBOUNCE_CYCLES-1.

Optional Feature:
PIO_DEBOUNCE_EN.
- Defined: debounce logic as described above.
- Undefined: the counters are not instantiated, and DEBOUNCE_CYCLES is ignored. d <= s2 every edge, and an accept event fires whenever s2 != d. A step reaches d and edgecapture 3 edges after the pin change, identical to DEBOUNCE_CYCLES=1.

Test Plan:
1. Reset with in_port=2'b00; read all addresses -> readdata 0 for every address, irq=0.
2. WIDTH=2, DEBOUNCE_CYCLES=16, EDGE_TYPE=0; write mask=2'b01; step in_port[0] to 1 -> DATA=1 and edgecapture[0]=1 exactly 18 edges after the step; irq=1 on the same edge.
3. Pulse in_port[1] high for 10 cycles (less than 16) -> DATA[1] stays 0, edgecapture[1] stays 0, irq unchanged.
4. With edgecapture=2'b01, write 0x1 to address 3 in the same cycle a new rising accept occurs on bit 0 -> edgecapture[0] remains 1; a subsequent clear with no new edge -> edgecapture=0 and irq=0 on the write edge.
5. EDGE_TYPE=2; toggle in_port[0] 1->0 and clear, then 0->1 -> each transition sets edgecapture[0]. EDGE_TYPE=1 -> only the 1->0 transition sets it.
6. Build without PIO_DEBOUNCE_EN; step in_port[1] -> DATA[1] updates 3 edges later; a 1-cycle glitch is captured as an edge.
